// File: rtl/spi_pkg.sv
// Shared SPI types and frame constants used by the master, the slave side and the verification env.
package spi_pkg;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_TURN    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_DONE    = 3'd5
  } master_state_e;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

endpackage

// File: rtl/spi_if.sv
// SPI bundle between master and slave; SCK is the shared system clock.
interface spi_if;
  logic SS_n;
  logic MOSI;
  logic MISO;

  modport SPI_MASTER (output SS_n, MOSI, input MISO);
  modport SPI_SLAVE  (input SS_n, MOSI, output MISO);
endinterface

// File: rtl/spi_cmd_master.sv
// Command-driven SPI master: serialises {cmd_type, cmd_data} frames and returns RD_DATA bytes.
module spi_cmd_master
  import spi_pkg::*;
#(
  parameter int TURN_CYCLES = 2,
  parameter int GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_type,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  master_state_e r_state;
  logic [9:0]    r_word;
  logic [3:0]    r_idx;
  logic [3:0]    r_cnt;
  logic [3:0]    r_gap;
  logic [6:0]    r_shift;
  logic          r_is_rd;
  logic          w_accept;

  assign w_accept = cmd_valid && cmd_ready;

  // Frame sequencer; every output is set one edge ahead so it is valid for the whole state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_word    <= 10'd0;
      r_idx     <= 4'd0;
      r_cnt     <= 4'd0;
      r_gap     <= 4'(GAP_CYCLES);
      r_shift   <= 7'd0;
      r_is_rd   <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      busy      <= 1'b0;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          SS_n <= 1'b1;
          MOSI <= 1'b0;
          if (w_accept) begin
            r_word    <= {cmd_type, cmd_data};
            r_is_rd   <= (cmd_type == RD_DATA);
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            SS_n      <= 1'b0;
            MOSI      <= cmd_type[1];
            r_state   <= ST_SELECT;
          end else if (r_gap != 4'd0) begin
            r_gap     <= r_gap - 4'd1;
            cmd_ready <= (r_gap == 4'd1);
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        ST_SELECT: begin
          MOSI    <= r_word[FRAME_BITS-1];
          r_idx   <= 4'(FRAME_BITS - 1);
          r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (r_idx != 4'd0) begin
            MOSI  <= r_word[r_idx - 4'd1];
            r_idx <= r_idx - 4'd1;
          end else begin
            MOSI <= 1'b0;
            if (r_is_rd) begin
              r_cnt   <= 4'(TURN_CYCLES - 1);
              r_state <= ST_TURN;
            end else begin
              SS_n    <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_TURN: begin
          if (r_cnt == 4'd0) begin
            r_cnt   <= 4'(DATA_BITS - 1);
            r_state <= ST_CAPTURE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_CAPTURE: begin
          // Last sample goes straight into rsp_data so it is valid alongside rsp_valid in DONE.
          r_shift <= {r_shift[5:0], MISO};
          if (r_cnt == 4'd0) begin
            rsp_data  <= {r_shift, MISO};
            rsp_valid <= 1'b1;
            SS_n      <= 1'b1;
            r_state   <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_DONE: begin
          busy    <= 1'b0;
          r_gap   <= 4'(GAP_CYCLES);
          r_state <= ST_IDLE;
        end
        default: begin
          SS_n    <= 1'b1;
          MOSI    <= 1'b0;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_master.sv
// Self-checking bench: vector table, hand-written corner sequences and random commands against a RAM-slave model.
module tb_spi_cmd_master;
  import spi_pkg::*;

  localparam int TURN = 2;
  localparam int GAP  = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_type = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       SS_n;
  logic       MOSI;
  logic       MISO = 1'b0;

  spi_cmd_master #(.TURN_CYCLES(TURN), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .busy(busy), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;
  int g_accept = 0;
  int g_done   = 0;

  // Slave/RAM model plus the byte rsp_data is expected to hold.
  logic [7:0] m_ram [256];
  logic [7:0] m_waddr = 8'h00;
  logic [7:0] m_raddr = 8'h00;
  logic [7:0] m_last_rsp = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // {SS_n, MOSI, rsp_valid, busy, cmd_ready, rsp_data}
  function automatic logic [31:0] status();
    return 32'({SS_n, MOSI, rsp_valid, busy, cmd_ready, rsp_data});
  endfunction

  function automatic logic [31:0] expst(input logic ss, input logic mo, input logic rv,
                                        input logic bz, input logic rdy, input logic [7:0] rd);
    return 32'({ss, mo, rv, bz, rdy, rd});
  endfunction

  // Present one command, follow its frame cycle by cycle; entered and left on a negedge.
  task automatic run_cmd(input string name, input logic [1:0] t, input logic [7:0] d,
                         input bit keep_valid, input int abort_k,
                         input bit exp_rv, input logic [7:0] exp_rd);
    logic [9:0] word;
    logic [7:0] rb;
    logic       exp_mosi;
    bit         acc;
    int         n_low;
    int         j;
    word  = {t, d};
    rb    = m_ram[m_raddr];
    n_low = (t == 2'b11) ? 11 + TURN + 8 : 11;
    cmd_valid = 1'b1;
    cmd_type  = t;
    cmd_data  = d;
    acc = 1'b0;
    for (int w = 0; w < 60; w++) begin
      if (cmd_ready === 1'b1) begin
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({name, " accept"}, 32'(acc), 32'd1);
    if (!acc) begin
      cmd_valid = 1'b0;
      return;
    end
    g_accept = cyc;
    for (int k = 1; k <= n_low + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        cmd_type = 2'($urandom);
        cmd_data = 8'($urandom);
        if (!keep_valid) cmd_valid = 1'b0;
      end
      j = k - (12 + TURN);
      MISO = (t == 2'b11 && j >= 0 && j < 8) ? rb[7-j] : 1'($urandom);
      if (k == abort_k) begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check({name, " abort outputs"}, status(), expst(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
        m_last_rsp = 8'h00;
        rst = 1'b0;
        check({name, " release ready low"}, status(), expst(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
        @(negedge clk);
        check({name, " release ready high"}, status(), expst(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00));
        return;
      end
      if (k <= n_low) begin
        exp_mosi = (k == 1) ? t[1] : ((k <= 11) ? word[11-k] : 1'b0);
        check({name, " frame"}, status(), expst(1'b0, exp_mosi, 1'b0, 1'b1, 1'b0, m_last_rsp));
      end else begin
        check({name, " done"}, status(),
              expst(1'b1, 1'b0, exp_rv, 1'b1, 1'b0, exp_rv ? exp_rd : m_last_rsp));
        if (exp_rv) m_last_rsp = exp_rd;
        g_done = cyc;
      end
    end
    case (t)
      2'b00:   m_waddr = d;
      2'b01:   m_ram[m_waddr] = d;
      2'b10:   m_raddr = d;
      default: ;
    endcase
  endtask

  typedef struct {
    string      name;
    logic [1:0] t;
    logic [7:0] d;
    bit         rv;
    logic [7:0] rd;
  } vec_t;

  vec_t tbl [10];
  bit   kv;
  bit   prev_kv;
  int   d1;
  logic [1:0] rt;
  logic [7:0] rdat;

  initial begin
    tbl[0] = '{"wr_addr_3c", 2'b00, 8'h3C, 1'b0, 8'h00};
    tbl[1] = '{"wr_data_a5", 2'b01, 8'hA5, 1'b0, 8'h00};
    tbl[2] = '{"rd_addr_3c", 2'b10, 8'h3C, 1'b0, 8'h00};
    tbl[3] = '{"rd_data_a5", 2'b11, 8'h00, 1'b1, 8'hA5};
    tbl[4] = '{"wr_addr_10", 2'b00, 8'h10, 1'b0, 8'h00};
    tbl[5] = '{"wr_data_5a", 2'b01, 8'h5A, 1'b0, 8'h00};
    tbl[6] = '{"rd_addr_10", 2'b10, 8'h10, 1'b0, 8'h00};
    tbl[7] = '{"rd_data_5a", 2'b11, 8'hFF, 1'b1, 8'h5A};
    tbl[8] = '{"rd_addr_77", 2'b10, 8'h77, 1'b0, 8'h00};
    tbl[9] = '{"rd_data_00", 2'b11, 8'h3C, 1'b1, 8'h00};
    for (int i = 0; i < 256; i++) m_ram[i] = 8'h00;

    repeat (3) @(negedge clk);
    check("reset outputs", status(), expst(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
    rst = 1'b0;
    check("ready low at release", status(), expst(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
    @(negedge clk);
    check("ready after gap", status(), expst(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00));
    for (int i = 0; i < 3; i++) begin
      MISO = 1'($urandom);
      @(negedge clk);
      check("idle steady", status(), expst(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00));
    end

    for (int i = 0; i < 10; i++) begin
      run_cmd(tbl[i].name, tbl[i].t, tbl[i].d, 1'b0, 0, tbl[i].rv, tbl[i].rd);
      repeat (2) @(negedge clk);
    end

    // cmd_valid held across two frames: second accepted two cycles after DONE, each sent once.
    run_cmd("b2b first", 2'b01, 8'h11, 1'b1, 0, 1'b0, 8'h00);
    d1 = g_done;
    run_cmd("b2b second", 2'b01, 8'h22, 1'b0, 0, 1'b0, 8'h00);
    check("b2b select spacing", 32'(g_accept + 1 - d1), 32'd3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("b2b no repeat", 32'({SS_n, busy}), 32'(2'b10));
    end
    run_cmd("rd_addr_10 again", 2'b10, 8'h10, 1'b0, 0, 1'b0, 8'h00);
    run_cmd("rd_data_22", 2'b11, 8'h00, 1'b0, 0, 1'b1, 8'h22);
    @(negedge clk);

    run_cmd("rd_data abort", 2'b11, 8'h00, 1'b0, 6, 1'b1, 8'h00);
    run_cmd("wr_addr_01 after abort", 2'b00, 8'h01, 1'b0, 0, 1'b0, 8'h00);

    prev_kv = 1'b0;
    for (int i = 0; i < 40; i++) begin
      rt   = 2'($urandom_range(0, 3));
      rdat = 8'($urandom);
      kv   = (i == 39) ? 1'b0 : 1'($urandom_range(0, 1));
      if (!prev_kv) repeat ($urandom_range(0, 3)) @(negedge clk);
      run_cmd("random", rt, rdat, kv, 0, rt == 2'b11, m_ram[m_raddr]);
      prev_kv = kv;
    end
    @(negedge clk);
    check("final rsp hold", 32'({rsp_data, busy}), 32'({m_last_rsp, 1'b0}));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spi_cmd_master.md
Name: spi_cmd_master

Overview:
- Upstream SPI master that drives the SPI slave/RAM wrapper's SS_n/MOSI and collects MISO.
- Accepts one command per valid/ready handshake from a host-side bus (test sequencer or CPU bridge) and serialises it as a wrapper frame.
- For read-data commands, returns the 8-bit RAM byte on a one-cycle response strobe.
- SCK equals clk; the wrapper samples MOSI on clk rising edges.

Parameters:
- TURN_CYCLES, 2, idle cycles between the last MOSI bit and the first MISO sample on a read-data frame (range 1..15).
- GAP_CYCLES, 1, minimum cycles SS_n stays high between frames (range 1..15).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  host presents a command.
- cmd_ready  output  1  master can accept a command (IDLE and gap expired).
- cmd_type  input  2  00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA.
- cmd_data  input  8  address or write data; ignored for RD_DATA (sent as-is).
- rsp_valid  output  1  one-cycle pulse, rsp_data valid.
- rsp_data  output  8  byte captured from MISO; holds until the next rsp_valid.
- busy  output  1  high from acceptance until return to IDLE.
- SS_n  output  1  slave select, active low.
- MOSI  output  1  serial data to the slave, MSB first.
- MISO  input  1  serial data from the slave.

Behaviour:
- Reset values: SS_n=1, MOSI=0, cmd_ready=0, rsp_valid=0, rsp_data=8'h00, busy=0. State=IDLE with the gap counter preloaded to GAP_CYCLES, so cmd_ready rises GAP_CYCLES cycles after rst deasserts.
- All outputs are registered. Acceptance cycle T is the cycle where cmd_valid&&cmd_ready are both high. The 10-bit frame word {cmd_type,cmd_data} is latched at T.
- States: IDLE, SELECT, SHIFT, TURN, CAPTURE, DONE.
- IDLE: SS_n=1, MOSI=0. Count down the gap counter; cmd_ready=1 once it reaches 0. On acceptance go to SELECT.
- SELECT (cycle T+1): SS_n=0, MOSI=cmd_type[1] (slave read/write select bit). Go to SHIFT with bit index 9.
- SHIFT (T+2..T+11): MOSI=word[idx], idx decrements 9→0.
  - After idx 0, RD_DATA goes to TURN; all other types go to DONE.
- TURN (TURN_CYCLES cycles): SS_n=0, MOSI=0.
- CAPTURE (8 cycles): SS_n=0, MOSI=0. Each cycle shift MISO into an 8-bit register, MSB first (rsp_data[7] = first sample).
- DONE (1 cycle): SS_n=1, MOSI=0. rsp_valid=1 only if the frame was RD_DATA, with rsp_data updated the same cycle. Reload the gap counter and go to IDLE.
- SS_n low durations:
  - Non-read frames: exactly 11 cycles (T+1..T+11).
  - RD_DATA frames: 11+TURN_CYCLES+8 cycles.
- busy is high from T+1 through DONE inclusive. cmd_ready=0 whenever busy.
- cmd_valid with cmd_ready=0 is held by the host and has no effect. A command is never dropped or duplicated.
- cmd_type/cmd_data changes after T do not affect the frame in flight.
- MISO is ignored outside CAPTURE.
- rst asserted mid-frame: next edge gives SS_n=1 and MOSI=0; no rsp_valid; the partial frame is discarded. After release, the gap rule applies.
- Back-to-back commands: the next acceptance happens no earlier than DONE+GAP_CYCLES+1.

Decomposition:
- Shared package spi_pkg holds:
  - cmd_e enum (WR_ADDR, WR_DATA, RD_ADDR, RD_DATA, 2 bits);
  - master_state_e enum;
  - FRAME_BITS=10 and DATA_BITS=8 constants, reused by the slave side and the UVM env.
- Single module, no sub-module needed; the shift/capture registers are trivial inline.
- A matching modport (SPI_MASTER: output SS_n, MOSI; input MISO) is added to the SPI interface.

Test Plan:
- Reset then idle: rst pulse, cmd_valid=0 → SS_n=1, MOSI=0, rsp_valid=0 throughout; cmd_ready rises 1 cycle after release (GAP=1).
- WR_ADDR 0x3C accepted at T → SS_n low T+1..T+11; MOSI sequence 0, then 0,0,0,0,1,1,1,1,0,0; SS_n=1 at T+12; no rsp_valid.
- WR_DATA 0xA5 to the wrapper loaded with address 0x3C → RAM[0x3C]=0xA5 after the frame.
- RD_ADDR 0x3C then RD_DATA with the slave model returning 0xA5 → MISO sampled T+14..T+21 (TURN=2); rsp_valid pulse at T+22 with rsp_data=8'hA5; SS_n low for 21 cycles.
- Back-to-back: cmd_valid held high with two WR_DATA commands → second SELECT exactly 3 cycles after the first DONE (gap 1 + IDLE accept); each command sent once.
- rst asserted at T+6 of a RD_DATA frame → SS_n=1 next edge, no rsp_valid; the following WR_ADDR 0x01 frame is bit-exact.
